// File: rtl/echo_tof_capture.sv
// rtl/echo_tof_capture.sv - ultrasonic echo time-of-flight capture after a burst
// Blanks transducer ringing, then times a glitch-filtered echo or reports a timeout.
module echo_tof_capture #(
  parameter int CNT_W       = 16,
  parameter int BLANK_CYC   = 480,
  parameter int TIMEOUT_CYC = 60000,
  parameter int ECHO_MIN_HI = 3
) (
  input  logic             gclk,
  input  logic             rst,
  input  logic             burst_finish,
  input  logic             echo_in,
  output logic             busy,
  output logic [CNT_W-1:0] tof_cnt,
  output logic             tof_timeout,
  output logic             tof_valid
);

  localparam int HI_W = $clog2(ECHO_MIN_HI + 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [HI_W-1:0]  HI_LAST    = HI_W'(ECHO_MIN_HI - 1);

  typedef enum logic [1:0] {IDLE, BLANK, LISTEN} state_t;

  state_t            state, state_nxt;
  logic              echo_m, echo_s, bf_d;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [HI_W-1:0]   hi_run, hi_run_nxt;
  logic              armed, armed_nxt;
  logic              start, detect, timeout;

  // bf_d resets high so a burst_finish level held across reset is not seen as an edge
  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      echo_m <= 1'b0;
      echo_s <= 1'b0;
      bf_d   <= 1'b1;
    end else begin
      echo_m <= echo_in;
      echo_s <= echo_m;
      bf_d   <= burst_finish;
    end
  end

  assign start   = burst_finish & ~bf_d;
  assign detect  = (state == LISTEN) & armed & echo_s & (hi_run == HI_LAST);
  assign timeout = (state == LISTEN) & (cnt == TO_LAST) & ~detect;

  always_ff @(posedge gclk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BLANK;
      BLANK:   if (cnt == BLANK_LAST) state_nxt = LISTEN;
      LISTEN:  if (detect | timeout) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Arming waits for echo_s to be low once, so ringing still high at LISTEN entry cannot detect
  always_comb begin
    cnt_nxt    = cnt;
    hi_run_nxt = hi_run;
    armed_nxt  = armed;
    case (state)
      IDLE: begin
        if (start) begin
          cnt_nxt    = '0;
          hi_run_nxt = '0;
          armed_nxt  = 1'b0;
        end
      end
      BLANK: cnt_nxt = cnt + CNT_W'(1);
      LISTEN: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (!echo_s) begin
          armed_nxt  = 1'b1;
          hi_run_nxt = '0;
        end else if (armed) begin
          hi_run_nxt = hi_run + HI_W'(1);
        end
      end
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      hi_run      <= '0;
      armed       <= 1'b0;
      busy        <= 1'b0;
      tof_cnt     <= '0;
      tof_timeout <= 1'b0;
      tof_valid   <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      hi_run    <= hi_run_nxt;
      armed     <= armed_nxt;
      busy      <= (state_nxt != IDLE);
      tof_valid <= detect | timeout;
      if (detect) begin
        tof_cnt     <= cnt;
        tof_timeout <= 1'b0;
      end else if (timeout) begin
        tof_cnt     <= '1;
        tof_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_echo_tof_capture.sv
// tb/tb_echo_tof_capture.sv - directed scoreboard bench for echo_tof_capture
// Echo patterns are given as masks of echo_s per cnt value; echo_in is driven two edges ahead.
module tb_echo_tof_capture;

  logic        gclk = 1'b0;
  logic        rst;
  logic        burst_finish;
  logic        echo_in;
  logic        busy;
  logic [15:0] tof_cnt;
  logic        tof_timeout;
  logic        tof_valid;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] cnt;
    logic        to;
    int          edge_idx;
  } exp_t;

  exp_t sb[$];

  echo_tof_capture #(
    .CNT_W(16), .BLANK_CYC(4), .TIMEOUT_CYC(20), .ECHO_MIN_HI(2)
  ) dut (
    .gclk(gclk), .rst(rst), .burst_finish(burst_finish), .echo_in(echo_in),
    .busy(busy), .tof_cnt(tof_cnt), .tof_timeout(tof_timeout), .tof_valid(tof_valid)
  );

  always #5 gclk = ~gclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge following start-relative edge idx
  task automatic watch(input string name, input int idx);
    exp_t e;
    if (tof_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk({name, "_unexpected_valid"}, 32'(tof_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk({name, "_tof_cnt"}, 32'(tof_cnt), 32'(e.cnt));
        chk({name, "_tof_timeout"}, 32'(tof_timeout), 32'(e.to));
        chk({name, "_valid_cycle"}, 32'(idx), 32'(e.edge_idx));
        chk({name, "_busy_at_valid"}, 32'(busy), 32'd0);
      end
    end
  endtask

  // Expects burst_finish low and to be called just after a negedge
  task automatic measure(input string name, input logic [31:0] mask, input int retrig,
                         input logic [15:0] exp_cnt, input logic exp_to);
    exp_t e;
    e.cnt      = exp_cnt;
    e.to       = exp_to;
    e.edge_idx = exp_to ? 20 : int'(exp_cnt) + 1;
    sb.push_back(e);
    burst_finish = 1'b1;
    echo_in      = mask[1];
    for (int m = 1; m <= 30; m++) begin
      @(negedge gclk);
      watch(name, m - 1);
      if (m == 1) chk({name, "_busy_rise"}, 32'(busy), 32'd1);
      burst_finish = (retrig >= 0) && (m == retrig + 1);
      echo_in      = mask[m + 1];
    end
    chk({name, "_drained"}, 32'(sb.size()), 32'd0);
    sb.delete();
    chk({name, "_idle_after"}, 32'(busy), 32'd0);
    chk({name, "_held_cnt"}, 32'(tof_cnt), 32'(exp_cnt));
    chk({name, "_held_timeout"}, 32'(tof_timeout), 32'(exp_to));
  endtask

  initial begin
    rst          = 1'b1;
    burst_finish = 1'b0;
    echo_in      = 1'b0;
    repeat (3) @(negedge gclk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_tof_cnt", 32'(tof_cnt), 32'd0);
    chk("reset_tof_timeout", 32'(tof_timeout), 32'd0);
    chk("reset_tof_valid", 32'(tof_valid), 32'd0);
    rst = 1'b0;
    @(negedge gclk);

    measure("nominal",   32'hFFFF_FC00, -1, 16'd11,   1'b0);
    measure("glitch",    32'hFFFF_F100, -1, 16'd13,   1'b0);
    measure("ringing",   32'hFFFF_FEFF, -1, 16'd10,   1'b0);
    measure("timeout",   32'h0000_0000, -1, 16'hFFFF, 1'b1);
    measure("never_arm", 32'hFFFF_FFFF, -1, 16'hFFFF, 1'b1);
    measure("retrigger", 32'hFFFF_FC00,  6, 16'd11,   1'b0);
    measure("boundary",  32'hFFFC_0000, -1, 16'd19,   1'b0);

    // Reset in LISTEN at cnt=7 with burst_finish left high
    burst_finish = 1'b1;
    echo_in      = 1'b0;
    for (int m = 1; m <= 8; m++) begin
      @(negedge gclk);
      watch("abort", m - 1);
    end
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_tof_cnt", 32'(tof_cnt), 32'd0);
    chk("abort_tof_timeout", 32'(tof_timeout), 32'd0);
    chk("abort_tof_valid", 32'(tof_valid), 32'd0);
    @(negedge gclk);
    rst = 1'b0;
    for (int m = 0; m < 6; m++) begin
      @(negedge gclk);
      chk("held_level_busy", 32'(busy), 32'd0);
      chk("held_level_valid", 32'(tof_valid), 32'd0);
    end
    burst_finish = 1'b0;
    @(negedge gclk);
    measure("post_reset", 32'hFFFF_FC00, -1, 16'd11, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
